perf_counters: RTL and testbench
================================

PERF_COUNTERS -- requirements
Module: perf_counters

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of every event counter.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-low reset (asserted at 0).
REQ-003 SHALL have ports: start, stop, clear  input  1 each  single-cycle control pulses from the debug/CP15 writer.
REQ-004 SHALL have ports: InstrE  input  32  execute-stage instruction; StallE, StallD, StalluOp, BranchE, BranchTakenE  input  1 each  pipeline status.
REQ-005 SHALL have ports: IStall, DStall, ldrStallD, PCSrcW, PCWrPendingF, FlushD, FlushE  input  1 each  stall, flush and hazard strobes.
REQ-006 SHALL have ports: rd_en  input  1  read request; rd_addr  input  4  counter select; rd_data  output  CNT_W  read value; rd_valid  output  1  rd_data qualifier.
REQ-007 SHALL have port running  output  1  high while in state RUN.

Function
REQ-008 SHALL implement states IDLE, RUN, FROZEN; IDLE->RUN on start; RUN->FROZEN on stop; FROZEN->RUN on start; any state->IDLE on clear.
REQ-009 SHALL give clear priority over start and stop; start and stop together in RUN SHALL go to FROZEN, in IDLE/FROZEN SHALL go to RUN.
REQ-010 SHALL, on clear, zero all counters, the overflow mask, the DStall run and max registers, in the same edge.
REQ-011 SHALL increment counters only on edges where state is RUN (pre-edge state); IDLE and FROZEN hold values.
REQ-012 Counter map: 0 cycles (every cycle); 1 retired instructions; 2 wasted (InstrE==0 or StallE); 3 uOp cycles (StallD & ~StalluOp).
REQ-013 Counter map: 4 branches (retire & BranchE); 5 taken branches (retire & BranchTakenE); 6 IStall rising edges; 7 DStall rising edges; 8 DStall cycles.
REQ-014 Counter map: 9 ldrStallD rising edges; 10 PCSrcW rising edges; 11 PCWrPendingF rising edges; 12 FlushD cycles; 13 FlushE cycles.
REQ-015 Retire SHALL be InstrE != previous-cycle InstrE and InstrE != 0.
REQ-016 Previous-value registers for InstrE and all edge-detected strobes SHALL update every cycle in every state, so a signal already high on entry to RUN is not counted.
REQ-017 Address 14 SHALL return the longest consecutive DStall run seen in RUN; the run counter resets to 0 on any cycle with DStall low.
REQ-018 Each counter SHALL saturate at all-ones and set its sticky bit in a 14-bit overflow mask; address 15 SHALL return the mask zero-extended.
REQ-019 On an edge with rd_en high, rd_data SHALL capture the selected value before that edge's update; rd_valid SHALL equal rd_en delayed one cycle.
REQ-020 rd_data SHALL hold its last value when rd_en is low; reads SHALL be legal in all states and not disturb counting.

Reset
REQ-021 Asserted reset SHALL force state IDLE, all counters, mask, run/max registers, previous-value registers, rd_data, rd_valid and running to 0 immediately.
REQ-022 Reset deasserted mid-run SHALL resume in IDLE; counting restarts only after a start pulse.

Structure
REQ-023 Package perf_pkg SHALL hold the state enum, the counter-index enum (0-15) and constant NUM_CNT = 14.
REQ-024 One sub-module perf_sat_counter (CNT_W-bit increment, clear, saturate, sticky overflow) SHALL be instantiated NUM_CNT times.

Verification
REQ-025 Reset, start, 10 cycles with InstrE=0, stop, read addr 0 and 2 -> both 10, rd_valid exactly one cycle after each rd_en.
REQ-026 In RUN, InstrE sequence 0x1,0x1,0x2,0x0,0x3 with BranchE high on 0x2 -> addr 1 = 3, addr 4 = 1.
REQ-027 DStall high 3 cycles, low 1, high 5 -> addr 7 = 2, addr 8 = 8, addr 14 = 5.
REQ-028 IStall held high across start, then low, then one 2-cycle pulse -> addr 6 = 1.
REQ-029 Force counter 0 to 0xFFFFFFFE via CNT_W=32 preload/backdoor, run 3 cycles -> addr 0 = 0xFFFFFFFF, addr 15 = 0x0001; clear -> both 0.
REQ-030 Assert reset while RUN with nonzero counters -> all outputs 0 in same cycle; start/stop/clear in one cycle -> IDLE, counters 0.

Source files
------------

// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perf_pkg
//  Description : Shared types and constants for the performance counter block:
//                control-state encoding, read-address map and counter count.
//  Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

    // Number of physical event counters (addresses 0..NUM_CNT-1)
    localparam int NUM_CNT = 14;

    // Control state machine
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_RUN    = ST_RUN;
    localparam logic [1:0] S_FROZEN = ST_FROZEN;

    // Read-address map: 0..13 are counters, 14 and 15 are derived registers
    typedef enum logic [3:0] {
        CNT_CYCLES      = 4'd0,
        CNT_RETIRED     = 4'd1,
        CNT_WASTED      = 4'd2,
        CNT_UOP         = 4'd3,
        CNT_BRANCH      = 4'd4,
        CNT_TAKEN       = 4'd5,
        CNT_ISTALL_EDGE = 4'd6,
        CNT_DSTALL_EDGE = 4'd7,
        CNT_DSTALL_CYC  = 4'd8,
        CNT_LDR_EDGE    = 4'd9,
        CNT_PCSRC_EDGE  = 4'd10,
        CNT_PCWR_EDGE   = 4'd11,
        CNT_FLUSHD      = 4'd12,
        CNT_FLUSHE      = 4'd13,
        CNT_DSTALL_MAX  = 4'd14,
        CNT_OVF_MASK    = 4'd15
    } cnt_idx_e;

endpackage
`default_nettype wire

// File: rtl/perf_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : perf_sat_counter
//  Description : Single saturating event counter with synchronous clear and a
//                sticky overflow flag raised when an increment hits all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_sat_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active low
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // Count up on request, stick at all-ones and remember that it happened
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (&count) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/perf_counters.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counters
//  Description : Pipeline performance monitor. Fourteen saturating event
//                counters gated by an IDLE/RUN/FROZEN control FSM, a longest
//                DStall-run tracker and a registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counters
    import perf_pkg::*;
#(
    parameter int CNT_W = 32             // must be >= NUM_CNT for the mask read
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [31:0]      InstrE,
    input  logic             StallE,
    input  logic             StallD,
    input  logic             StalluOp,
    input  logic             BranchE,
    input  logic             BranchTakenE,
    input  logic             IStall,
    input  logic             DStall,
    input  logic             ldrStallD,
    input  logic             PCSrcW,
    input  logic             PCWrPendingF,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             rd_en,
    input  logic [3:0]       rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             running
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               run_now;

    logic [31:0]        prev_instr;
    logic               prev_istall;
    logic               prev_dstall;
    logic               prev_ldr;
    logic               prev_pcsrc;
    logic               prev_pcwr;

    logic               retire;
    logic [NUM_CNT-1:0] event_hit;
    logic [CNT_W-1:0]   counts [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_mask;

    logic [CNT_W-1:0]   dstall_run;
    logic [CNT_W-1:0]   dstall_run_inc;
    logic [CNT_W-1:0]   dstall_max;

    logic [CNT_W-1:0]   rd_sources [16];
    logic [CNT_W-1:0]   mask_ext;

    // Next-state logic: clear wins, start+stop toggles between RUN and FROZEN
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_RUN;
                S_RUN:    if (stop)  state_nxt = S_FROZEN;
                S_FROZEN: if (start) state_nxt = S_RUN;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign run_now = (state == S_RUN);
    assign running = run_now;

    // History of edge-detected inputs, tracked in every state so a level that
    // is already high when counting starts does not look like a new edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_instr  <= '0;
            prev_istall <= 1'b0;
            prev_dstall <= 1'b0;
            prev_ldr    <= 1'b0;
            prev_pcsrc  <= 1'b0;
            prev_pcwr   <= 1'b0;
        end else begin
            prev_instr  <= InstrE;
            prev_istall <= IStall;
            prev_dstall <= DStall;
            prev_ldr    <= ldrStallD;
            prev_pcsrc  <= PCSrcW;
            prev_pcwr   <= PCWrPendingF;
        end
    end

    // A new, non-bubble instruction in execute counts as one retirement
    assign retire = (InstrE != prev_instr) && (InstrE != 32'd0);

    // Per-counter event decode
    always_comb begin
        event_hit                  = '0;
        event_hit[CNT_CYCLES]      = 1'b1;
        event_hit[CNT_RETIRED]     = retire;
        event_hit[CNT_WASTED]      = (InstrE == 32'd0) || StallE;
        event_hit[CNT_UOP]         = StallD && !StalluOp;
        event_hit[CNT_BRANCH]      = retire && BranchE;
        event_hit[CNT_TAKEN]       = retire && BranchTakenE;
        event_hit[CNT_ISTALL_EDGE] = IStall && !prev_istall;
        event_hit[CNT_DSTALL_EDGE] = DStall && !prev_dstall;
        event_hit[CNT_DSTALL_CYC]  = DStall;
        event_hit[CNT_LDR_EDGE]    = ldrStallD && !prev_ldr;
        event_hit[CNT_PCSRC_EDGE]  = PCSrcW && !prev_pcsrc;
        event_hit[CNT_PCWR_EDGE]   = PCWrPendingF && !prev_pcwr;
        event_hit[CNT_FLUSHD]      = FlushD;
        event_hit[CNT_FLUSHE]      = FlushE;
    end

    generate
        for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
            perf_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .clear    (clear),
                .inc      (run_now && event_hit[i]),
                .count    (counts[i]),
                .overflow (ovf_mask[i])
            );
        end
    endgenerate

    assign dstall_run_inc = (&dstall_run) ? dstall_run : dstall_run + 1'b1;

    // Longest consecutive DStall run observed while counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dstall_run <= '0;
            dstall_max <= '0;
        end else if (clear) begin
            dstall_run <= '0;
            dstall_max <= '0;
        end else if (!DStall) begin
            dstall_run <= '0;
        end else if (run_now) begin
            dstall_run <= dstall_run_inc;
            if (dstall_run_inc > dstall_max) begin
                dstall_max <= dstall_run_inc;
            end
        end
    end

    assign mask_ext = {{(CNT_W - NUM_CNT){1'b0}}, ovf_mask};

    // Read-address map into a flat 16-entry view
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rd_sources[i] = '0;
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            rd_sources[i] = counts[i];
        end
        rd_sources[CNT_DSTALL_MAX] = dstall_max;
        rd_sources[CNT_OVF_MASK]   = mask_ext;
    end

    // Registered read port: captures pre-update values, holds when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_sources[rd_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_counters.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_counters
//  Description : Directed self-checking bench for perf_counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counters;

    logic        clk;
    logic        reset;
    logic        start, stop, clear;
    logic [31:0] InstrE;
    logic        StallE, StallD, StalluOp, BranchE, BranchTakenE;
    logic        IStall, DStall, ldrStallD, PCSrcW, PCWrPendingF, FlushD, FlushE;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        running;

    int n_assert;
    int n_fail;

    perf_counters #(.CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .InstrE       (InstrE),
        .StallE       (StallE),
        .StallD       (StallD),
        .StalluOp     (StalluOp),
        .BranchE      (BranchE),
        .BranchTakenE (BranchTakenE),
        .IStall       (IStall),
        .DStall       (DStall),
        .ldrStallD    (ldrStallD),
        .PCSrcW       (PCSrcW),
        .PCWrPendingF (PCWrPendingF),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    // Read one address: data and valid one cycle after rd_en, then valid drops and data holds
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        rd_en = 1'b1; rd_addr = a;
        step();
        chk({tag, "_data"}, rd_data, exp);
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        rd_en = 1'b0;
        step();
        chk({tag, "_valid_drop"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_hold"}, rd_data, exp);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        InstrE = 32'd0;
        StallE = 1'b0; StallD = 1'b0; StalluOp = 1'b0; BranchE = 1'b0; BranchTakenE = 1'b0;
        IStall = 1'b0; DStall = 1'b0; ldrStallD = 1'b0; PCSrcW = 1'b0; PCWrPendingF = 1'b0;
        FlushD = 1'b0; FlushE = 1'b0;
        rd_en = 1'b0; rd_addr = 4'd0;

        // ---- reset state
        step(); step();
        chk("rst_running",  {31'd0, running},  32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data",  rd_data,           32'd0);
        reset = 1'b1;
        step();
        chk("idle_running", {31'd0, running}, 32'd0);

        // ---- 10 counted cycles with InstrE = 0
        pulse_start();
        chk("start_running", {31'd0, running}, 32'd1);
        repeat (9) step();
        pulse_stop();
        chk("stop_running", {31'd0, running}, 32'd0);
        rd(4'd0, 32'd10, "cycles10");
        rd(4'd2, 32'd10, "wasted10");
        rd(4'd1, 32'd0,  "retired0");

        // ---- retire / branch sequence
        pulse_clear();
        rd(4'd0, 32'd0, "clr_cycles");
        pulse_start();
        InstrE = 32'h1; step();
        InstrE = 32'h1; step();
        InstrE = 32'h2; BranchE = 1'b1; step();
        InstrE = 32'h0; BranchE = 1'b0; step();
        InstrE = 32'h3; step();
        InstrE = 32'h0;
        pulse_stop();
        rd(4'd1, 32'd3, "retired3");
        rd(4'd4, 32'd1, "branch1");
        rd(4'd5, 32'd0, "taken0");
        rd(4'd0, 32'd6, "cycles6");
        rd(4'd2, 32'd2, "wasted2");

        // ---- DStall runs: 3 high, 1 low, 5 high
        pulse_clear();
        pulse_start();
        DStall = 1'b1; repeat (3) step();
        DStall = 1'b0; step();
        DStall = 1'b1; repeat (5) step();
        DStall = 1'b0;
        pulse_stop();
        rd(4'd7,  32'd2, "dstall_edges");
        rd(4'd8,  32'd8, "dstall_cycles");
        rd(4'd14, 32'd5, "dstall_max");

        // ---- IStall already high on entry to RUN is not an edge
        pulse_clear();
        IStall = 1'b1; step();
        pulse_start();
        step();
        IStall = 1'b0; step();
        IStall = 1'b1; step(); step();
        IStall = 1'b0; step();
        pulse_stop();
        rd(4'd6, 32'd1, "istall_edges");

        // ---- saturation of counter 0 from a preloaded value
        pulse_clear();
        force dut.g_cnt[0].u_cnt.count = 32'hFFFF_FFFE;
        step();
        release dut.g_cnt[0].u_cnt.count;
        step();
        pulse_start();
        step(); step();
        pulse_stop();
        rd(4'd0,  32'hFFFF_FFFF, "sat_cycles");
        rd(4'd15, 32'h0000_0001, "ovf_mask");
        pulse_clear();
        rd(4'd0,  32'd0, "sat_clr_cycles");
        rd(4'd15, 32'd0, "sat_clr_mask");

        // ---- asynchronous reset in RUN with nonzero counters
        pulse_start();
        repeat (3) step();
        rd_en = 1'b1; rd_addr = 4'd0;
        step();
        chk("pre_rst_data", rd_data, 32'd3);
        rd_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rst_running",  {31'd0, running},  32'd0);
        chk("async_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("async_rst_rd_data",  rd_data,           32'd0);
        step();
        reset = 1'b1;
        step(); step();
        chk("post_rst_idle", {31'd0, running}, 32'd0);
        rd(4'd0, 32'd0, "post_rst_cycles");

        // ---- simultaneous control pulses
        start = 1'b1; stop = 1'b1; step();
        chk("ss_idle_to_run", {31'd0, running}, 32'd1);
        step();
        chk("ss_run_to_frozen", {31'd0, running}, 32'd0);
        step();
        chk("ss_frozen_to_run", {31'd0, running}, 32'd1);
        clear = 1'b1; step();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        chk("all3_idle", {31'd0, running}, 32'd0);
        rd(4'd0, 32'd0, "all3_cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
